// File: rtl/ahb_slave_if_mc_if.sv
// rtl/ahb_slave_if_mc_if.sv - AHB-Lite slave front-end bus bundle
interface ahb_slave_if_mc_if #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int N_SEL      = 3,
  parameter int PIPE_DEPTH = 2
);
  logic                         hwrite;
  logic                         hreadyin;
  logic [1:0]                   htrans;
  logic [ADDR_W-1:0]            haddr;
  logic [DATA_W-1:0]            hwdata;
  logic [DATA_W-1:0]            prdata;
  logic                         bridge_ready;
  logic [DATA_W-1:0]            hrdata;
  logic                         hreadyout;
  logic [1:0]                   hresp;
  logic [PIPE_DEPTH*ADDR_W-1:0] haddr_pipe;
  logic [PIPE_DEPTH*DATA_W-1:0] hwdata_pipe;
  logic [PIPE_DEPTH-1:0]        hwrite_pipe;
  logic                         valid;
  logic [N_SEL-1:0]             temp_selx;

  modport slave (
    input  hwrite, hreadyin, htrans, haddr, hwdata, prdata, bridge_ready,
    output hrdata, hreadyout, hresp, haddr_pipe, hwdata_pipe, hwrite_pipe, valid, temp_selx
  );

  modport master (
    output hwrite, hreadyin, htrans, haddr, hwdata, prdata, bridge_ready,
    input  hrdata, hreadyout, hresp, haddr_pipe, hwdata_pipe, hwrite_pipe, valid, temp_selx
  );
endinterface

// File: rtl/ahb_slave_if_mc.sv
// rtl/ahb_slave_if_mc.sv - AHB-Lite slave front end: region decode, pipelines, ERROR response
// Optional transfer/error counters are built when AHB_IF_STATS_EN is defined.
module ahb_slave_if_mc #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                N_SEL       = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                REGION_LOG2 = 26,
  parameter int                PIPE_DEPTH  = 2
) (
  input  logic              hclk,
  input  logic              hreset,
  ahb_slave_if_mc_if.slave  bus
`ifdef AHB_IF_STATS_EN
  ,
  output logic [15:0]       xfer_cnt,
  output logic [15:0]       err_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ERR1, S_ERR2} state_t;

  state_t                       state_q, state_d;
  logic [ADDR_W:0]              off;
  logic [ADDR_W:0]              region;
  logic                         mapped;
  logic                         active;
  logic [N_SEL-1:0]             sel;
  logic                         valid_c;
  logic                         hreadyout_c;
  logic [1:0]                   hresp_c;
  logic [PIPE_DEPTH*ADDR_W-1:0] addr_pipe;
  logic [PIPE_DEPTH*DATA_W-1:0] wdata_pipe;
  logic [PIPE_DEPTH-1:0]        write_pipe;

  // One extra bit keeps addresses below BASE_ADDR from aliasing into a region.
  assign off    = {1'b0, bus.haddr} - {1'b0, BASE_ADDR};
  assign region = off >> REGION_LOG2;
  assign mapped = (bus.haddr >= BASE_ADDR) && (region < (ADDR_W+1)'(N_SEL));
  assign active = bus.hreadyin && bus.htrans[1];

  always_comb begin
    sel = '0;
    for (int i = 0; i < N_SEL; i++) begin
      sel[i] = mapped && (region == (ADDR_W+1)'(i));
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hresp_c     = 2'b00;
    hreadyout_c = 1'b1;
    valid_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        hreadyout_c = bus.bridge_ready;
        valid_c     = active && mapped;
        // The error path does not wait for the bridge to be ready.
        if (active && !mapped) begin
          state_d = S_ERR1;
        end
      end
      S_ERR1: begin
        hresp_c     = 2'b01;
        hreadyout_c = 1'b0;
        state_d     = S_ERR2;
      end
      S_ERR2: begin
        hresp_c     = 2'b01;
        hreadyout_c = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      addr_pipe  <= '0;
      wdata_pipe <= '0;
      write_pipe <= '0;
    end else begin
      addr_pipe[ADDR_W-1:0]  <= bus.haddr;
      wdata_pipe[DATA_W-1:0] <= bus.hwdata;
      write_pipe[0]          <= bus.hwrite;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        addr_pipe[k*ADDR_W +: ADDR_W]  <= addr_pipe[(k-1)*ADDR_W +: ADDR_W];
        wdata_pipe[k*DATA_W +: DATA_W] <= wdata_pipe[(k-1)*DATA_W +: DATA_W];
        write_pipe[k]                  <= write_pipe[k-1];
      end
    end
  end

  assign bus.hrdata      = bus.prdata;
  assign bus.hreadyout   = hreadyout_c;
  assign bus.hresp       = hresp_c;
  assign bus.valid       = valid_c;
  assign bus.temp_selx   = sel;
  assign bus.haddr_pipe  = addr_pipe;
  assign bus.hwdata_pipe = wdata_pipe;
  assign bus.hwrite_pipe = write_pipe;

`ifdef AHB_IF_STATS_EN
  logic err_start;
  assign err_start = (state_q == S_IDLE) && (state_d == S_ERR1);

  always_ff @(posedge hclk) begin
    if (hreset) begin
      xfer_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (valid_c && (xfer_cnt != 16'hFFFF)) begin
        xfer_cnt <= xfer_cnt + 16'd1;
      end
      if (err_start && (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ahb_slave_if_mc.sv
// tb/tb_ahb_slave_if_mc.sv - randomized, model-checked bench for ahb_slave_if_mc
module tb_ahb_slave_if_mc;
  localparam int          ADDR_W      = 32;
  localparam int          DATA_W      = 32;
  localparam int          N_SEL       = 3;
  localparam int          REGION_LOG2 = 26;
  localparam int          PIPE_DEPTH  = 2;
  localparam logic [31:0] BASE        = 32'h8000_0000;

  logic hclk = 1'b0;
  logic hreset;
  always #5 hclk = ~hclk;

  ahb_slave_if_mc_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_SEL(N_SEL), .PIPE_DEPTH(PIPE_DEPTH)) bus ();

`ifdef AHB_IF_STATS_EN
  logic [15:0] xfer_cnt, err_cnt;
`endif

  ahb_slave_if_mc #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_SEL(N_SEL), .BASE_ADDR(BASE),
    .REGION_LOG2(REGION_LOG2), .PIPE_DEPTH(PIPE_DEPTH)
  ) dut (
    .hclk(hclk),
    .hreset(hreset),
    .bus(bus)
`ifdef AHB_IF_STATS_EN
    ,
    .xfer_cnt(xfer_cnt),
    .err_cnt(err_cnt)
`endif
  );

  int n_total = 0;
  int n_pass  = 0;

  // reference model: phase 0 = OKAY, 1 = first ERROR cycle, 2 = second ERROR cycle
  logic [31:0] m_addr [PIPE_DEPTH];
  logic [31:0] m_wd   [PIPE_DEPTH];
  logic        m_wr   [PIPE_DEPTH];
  int          m_phase = 0;
  bit          m_known = 1'b0;
  int          m_xfer  = 0;
  int          m_err   = 0;

  logic [1:0]                   o_hresp;
  logic                         o_rdy, o_valid;
  logic [N_SEL-1:0]             o_sel;
  logic [PIPE_DEPTH*ADDR_W-1:0] o_apipe;
  logic [PIPE_DEPTH*DATA_W-1:0] o_wpipe;
  logic [PIPE_DEPTH-1:0]        o_wrpipe;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int region_of(input logic [31:0] a);
    longint unsigned o;
    if (a < BASE) return -1;
    o = {32'd0, a} - {32'd0, BASE};
    if (o / (64'd1 << REGION_LOG2) >= N_SEL) return -1;
    return int'(o / (64'd1 << REGION_LOG2));
  endfunction

  task automatic step(input logic rst, input logic [1:0] tr, input logic rdy, input logic [31:0] a,
                      input logic wr, input logic [31:0] wd, input logic brdy, input logic [31:0] pr);
    int                           reg_i;
    logic                         act;
    logic [N_SEL-1:0]             e_sel;
    logic [PIPE_DEPTH*ADDR_W-1:0] e_ap;
    logic [PIPE_DEPTH*DATA_W-1:0] e_wp;
    logic [PIPE_DEPTH-1:0]        e_wrp;
    hreset = rst; bus.htrans = tr; bus.hreadyin = rdy; bus.haddr = a;
    bus.hwrite = wr; bus.hwdata = wd; bus.bridge_ready = brdy; bus.prdata = pr;
    reg_i = region_of(a);
    act   = rdy && tr[1];
    e_sel = (reg_i >= 0) ? (N_SEL'(1) << reg_i) : '0;
    @(negedge hclk);
    o_hresp = bus.hresp; o_rdy = bus.hreadyout; o_valid = bus.valid; o_sel = bus.temp_selx;
    o_apipe = bus.haddr_pipe; o_wpipe = bus.hwdata_pipe; o_wrpipe = bus.hwrite_pipe;
    check("hrdata", bus.hrdata, pr);
    check("temp_selx", o_sel, e_sel);
    if (m_known) begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        e_ap[k*ADDR_W +: ADDR_W] = m_addr[k];
        e_wp[k*DATA_W +: DATA_W] = m_wd[k];
        e_wrp[k] = m_wr[k];
      end
      check("hresp", o_hresp, (m_phase == 0) ? 2'b00 : 2'b01);
      check("hreadyout", o_rdy, (m_phase == 0) ? brdy : (m_phase == 2));
      check("valid", o_valid, (m_phase == 0) && act && (reg_i >= 0));
      check("haddr_pipe", o_apipe, e_ap);
      check("hwdata_pipe", o_wpipe, e_wp);
      check("hwrite_pipe", o_wrpipe, e_wrp);
`ifdef AHB_IF_STATS_EN
      check("xfer_cnt", xfer_cnt, 16'(m_xfer));
      check("err_cnt", err_cnt, 16'(m_err));
`endif
    end
    @(posedge hclk);
    #1;
    if (rst) begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        m_addr[k] = '0; m_wd[k] = '0; m_wr[k] = 1'b0;
      end
      m_phase = 0; m_known = 1'b1; m_xfer = 0; m_err = 0;
    end else begin
      if (m_phase == 0 && act && reg_i >= 0 && m_xfer < 65535) m_xfer++;
      if (m_phase == 0 && act && reg_i < 0 && m_err < 65535) m_err++;
      for (int k = PIPE_DEPTH - 1; k > 0; k--) begin
        m_addr[k] = m_addr[k-1]; m_wd[k] = m_wd[k-1]; m_wr[k] = m_wr[k-1];
      end
      m_addr[0] = a; m_wd[0] = wd; m_wr[0] = wr;
      if (m_phase == 1)                 m_phase = 2;
      else if (m_phase == 2)            m_phase = 0;
      else if (act && reg_i < 0)        m_phase = 1;
      else                              m_phase = 0;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return BASE + ($urandom_range(0, 4) << REGION_LOG2) + ($urandom & 32'h03FF_FFFC);
      1:       return BASE - 32'd4;
      2:       return 32'h8BFF_FFFC;
      3:       return 32'h8C00_0000;
      4:       return $urandom;
      default: return 32'hFFFF_FFFC;
    endcase
  endfunction

  initial begin
    // reset with random inputs
    step(1'b1, 2'($urandom), 1'($urandom), $urandom, 1'($urandom), $urandom, 1'b1, $urandom);
    step(1'b1, 2'($urandom), 1'($urandom), $urandom, 1'($urandom), $urandom, 1'b1, $urandom);
    step(1'b0, 2'b00, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
    check("rst_hresp", o_hresp, 2'b00);
    check("rst_hreadyout", o_rdy, 1'b1);
    check("rst_apipe", o_apipe, '0);
    check("rst_valid", o_valid, 1'b0);

    // decode
    step(1'b0, 2'b10, 1'b1, 32'h8400_0010, 1'b0, 32'h0, 1'b1, 32'h1234);
    check("dec_valid", o_valid, 1'b1);
    check("dec_sel1", o_sel, 3'b010);
    step(1'b0, 2'b10, 1'b1, 32'h8BFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0);
    check("dec_sel2", o_sel, 3'b100);
    step(1'b0, 2'b10, 1'b1, 32'h7FFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0);
    check("dec_below", o_sel, 3'b000);
    step(1'b0, 2'b10, 1'b1, 32'h8C00_0000, 1'b0, 32'h0, 1'b1, 32'h0);
    check("dec_above", o_sel, 3'b000);
    step(1'b0, 2'b00, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);

    // pipeline
    step(1'b0, 2'b00, 1'b1, 32'hA000_0000, 1'b1, 32'hD000_0000, 1'b1, 32'h0);
    step(1'b0, 2'b00, 1'b1, 32'hA111_1111, 1'b0, 32'hD111_1111, 1'b1, 32'h0);
    step(1'b0, 2'b00, 1'b1, 32'hA222_2222, 1'b1, 32'hD222_2222, 1'b1, 32'h0);
    check("pipe_a_s1", o_apipe[63:32], 32'hA000_0000);
    check("pipe_a_s0", o_apipe[31:0], 32'hA111_1111);
    check("pipe_d_s1", o_wpipe[63:32], 32'hD000_0000);
    check("pipe_w", o_wrpipe, 2'b10);

    // error response, mapped NONSEQ during ERR1/ERR2 ignored; bridge not ready
    step(1'b0, 2'b10, 1'b1, 32'h9000_0000, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 2'b10, 1'b1, 32'h8000_0000, 1'b0, 32'h0, 1'b1, 32'h0);
    check("err1_hresp", o_hresp, 2'b01);
    check("err1_rdy", o_rdy, 1'b0);
    check("err1_valid", o_valid, 1'b0);
    step(1'b0, 2'b10, 1'b1, 32'h8000_0000, 1'b0, 32'h0, 1'b1, 32'h0);
    check("err2_hresp", o_hresp, 2'b01);
    check("err2_rdy", o_rdy, 1'b1);
    check("err2_valid", o_valid, 1'b0);
    step(1'b0, 2'b00, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
    check("err_done", o_hresp, 2'b00);

    // qualifiers
    step(1'b0, 2'b01, 1'b1, 32'h8000_0100, 1'b0, 32'h0, 1'b1, 32'h0);
    check("q_busy", o_valid, 1'b0);
    step(1'b0, 2'b00, 1'b1, 32'h8000_0100, 1'b0, 32'h0, 1'b1, 32'h0);
    check("q_idle", o_valid, 1'b0);
    step(1'b0, 2'b11, 1'b0, 32'h8000_0100, 1'b0, 32'h0, 1'b1, 32'h0);
    check("q_notready", o_valid, 1'b0);

    // reset aborts ERR1
    step(1'b0, 2'b11, 1'b1, 32'hFFFF_0000, 1'b0, 32'h0, 1'b1, 32'h0);
    step(1'b1, 2'b00, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
    check("rst_err1_hresp", o_hresp, 2'b01);
    step(1'b0, 2'b00, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
    check("rst_abort_hresp", o_hresp, 2'b00);
    check("rst_abort_rdy", o_rdy, 1'b1);

`ifdef AHB_IF_STATS_EN
    step(1'b1, 2'b00, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 2'b10, 1'b1, BASE + (i << REGION_LOG2), 1'b1, 32'h0, 1'b1, 32'h0);
    step(1'b0, 2'b10, 1'b1, 32'h9000_0000, 1'b0, 32'h0, 1'b1, 32'h0);
    step(1'b0, 2'b00, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
    step(1'b0, 2'b00, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
    check("stat_xfer", xfer_cnt, 16'd3);
    check("stat_err", err_cnt, 16'd1);
`endif

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 39) == 0, 2'($urandom), $urandom_range(0, 3) != 0, rand_addr(),
           1'($urandom), $urandom, $urandom_range(0, 3) != 0, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
